// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared FSM encoding and burst geometry check for sdram_burst_arbiter
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_WR_REQ  = 3'd1,
    ARB_WR_BUSY = 3'd2,
    ARB_RD_REQ  = 3'd3,
    ARB_RD_BUSY = 3'd4
  } arb_state_e;

  function automatic bit burst_len_ok(input longint unsigned burst_len,
                                      input longint unsigned mem_words);
    return (burst_len != 0) && ((burst_len & (burst_len - 1)) == 0) &&
           ((mem_words % burst_len) == 0);
  endfunction

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// rtl/sdram_burst_arbiter_if.sv - burst trigger/ack/done handshake between arbiter and SDRAM controller
interface sdram_burst_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              wr_trig;
  logic              wr_ack;
  logic              wr_done;
  logic              rd_trig;
  logic              rd_ack;
  logic              rd_done;
  logic [ADDR_W-1:0] burst_addr;

  modport master (
    output wr_trig, rd_trig, burst_addr,
    input  wr_ack, wr_done, rd_ack, rd_done
  );

  modport slave (
    input  wr_trig, rd_trig, burst_addr,
    output wr_ack, wr_done, rd_ack, rd_done
  );
endinterface

// File: rtl/sdram_burst_arbiter_burst_ptr.sv
// rtl/sdram_burst_arbiter_burst_ptr.sv - ring-buffer burst pointer, advances by BURST_LEN and wraps at MEM_WORDS
module burst_ptr #(
  parameter int ADDR_W    = 22,
  parameter int BURST_LEN = 256,
  parameter int MEM_WORDS = 4194304
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] ptr_o
);
  localparam logic [ADDR_W:0] STEP = (ADDR_W + 1)'(BURST_LEN);
  localparam logic [ADDR_W:0] WRAP = (ADDR_W + 1)'(MEM_WORDS);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   sum;

  // One extra bit so MEM_WORDS == 2**ADDR_W still compares correctly.
  always_comb begin
    sum   = {1'b0, ptr_q} + STEP;
    ptr_d = ptr_q;
    if (adv_i) ptr_d = (sum == WRAP) ? '0 : sum[ADDR_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;
endmodule

// File: rtl/sdram_burst_arbiter.sv
// rtl/sdram_burst_arbiter.sv - SDRAM burst scheduler between write/read FIFOs and the controller
// Optional ARB_RR_EN: round-robin IDLE arbitration instead of fixed write priority.
module sdram_burst_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int CNT_W        = 9,
  parameter int FIFO_DEPTH   = 512,
  parameter int BURST_LEN    = 256,
  parameter int ADDR_W       = 22,
  parameter int MEM_WORDS    = 4194304,
  parameter int RD_READY_LVL = 243
) (
  input  logic                 wfifo_rclk,
  input  logic                 s_rst_n,
  input  logic [CNT_W-1:0]     wfifo_rside_usedw,
  input  logic [CNT_W-1:0]     rfifo_wside_usedw,
  sdram_burst_arbiter_if.master ctrl,
  output logic [ADDR_W:0]      sdram_level,
  output logic                 rfifo_rd_ready
);
  localparam int LW = ADDR_W + 1;
  localparam logic [ADDR_W:0] BL      = LW'(BURST_LEN);
  localparam logic [ADDR_W:0] WR_ROOM = LW'(MEM_WORDS - BURST_LEN);
  localparam logic [ADDR_W:0] RD_ROOM = LW'(FIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_W:0] RDY_LVL = LW'(RD_READY_LVL);

  localparam logic [2:0] ST_IDLE    = ARB_IDLE;
  localparam logic [2:0] ST_WR_REQ  = ARB_WR_REQ;
  localparam logic [2:0] ST_WR_BUSY = ARB_WR_BUSY;
  localparam logic [2:0] ST_RD_REQ  = ARB_RD_REQ;
  localparam logic [2:0] ST_RD_BUSY = ARB_RD_BUSY;

  if (!burst_len_ok(BURST_LEN, MEM_WORDS)) begin : g_bad_geometry
    $error("BURST_LEN must be a power of two that divides MEM_WORDS");
  end

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   lvl_q, lvl_d;
  logic              wr_trig_q, rd_trig_q;
  logic              rd_seen_q, rd_seen_d;
  logic              rdy_q, rdy_d;
  logic              last_wr_q, last_wr_d;
  logic              wr_pend, rd_pend, wr_win, wr_fin, rd_fin;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  burst_ptr #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .MEM_WORDS(MEM_WORDS)) u_wr_ptr (
    .clk_i(wfifo_rclk), .rst_n_i(s_rst_n), .adv_i(wr_fin), .ptr_o(wr_ptr)
  );

  burst_ptr #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .MEM_WORDS(MEM_WORDS)) u_rd_ptr (
    .clk_i(wfifo_rclk), .rst_n_i(s_rst_n), .adv_i(rd_fin), .ptr_o(rd_ptr)
  );

  always_comb begin
    wr_pend = (LW'(wfifo_rside_usedw) >= BL) && (lvl_q <= WR_ROOM);
    rd_pend = (lvl_q >= BL) && (LW'(rfifo_wside_usedw) <= RD_ROOM);
`ifdef ARB_RR_EN
    wr_win  = wr_pend && (!rd_pend || !last_wr_q);
`else
    wr_win  = wr_pend;
`endif
    // Same-cycle ack+done in REQ counts as a finished burst.
    wr_fin  = ctrl.wr_done && (((state_q == ST_WR_REQ) && ctrl.wr_ack) || (state_q == ST_WR_BUSY));
    rd_fin  = ctrl.rd_done && (((state_q == ST_RD_REQ) && ctrl.rd_ack) || (state_q == ST_RD_BUSY));
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lvl_d     = lvl_q;
    rd_seen_d = rd_seen_q;
    last_wr_d = last_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_win) begin
          state_d   = ST_WR_REQ;
          addr_d    = wr_ptr;
          last_wr_d = 1'b1;
        end else if (rd_pend) begin
          state_d   = ST_RD_REQ;
          addr_d    = rd_ptr;
          last_wr_d = 1'b0;
        end
      end
      ST_WR_REQ:  if (ctrl.wr_ack) state_d = ST_WR_BUSY;
      ST_RD_REQ:  if (ctrl.rd_ack) state_d = ST_RD_BUSY;
      ST_WR_BUSY, ST_RD_BUSY: ;
      default:    state_d = ST_IDLE;
    endcase
    if (wr_fin) begin
      state_d = ST_IDLE;
      lvl_d   = lvl_q + BL;
    end
    if (rd_fin) begin
      state_d   = ST_IDLE;
      lvl_d     = lvl_q - BL;
      rd_seen_d = 1'b1;
    end
    rdy_d = rdy_q || (rd_seen_q && (LW'(rfifo_wside_usedw) >= RDY_LVL));
  end

  always_ff @(posedge wfifo_rclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      lvl_q     <= '0;
      wr_trig_q <= 1'b0;
      rd_trig_q <= 1'b0;
      rd_seen_q <= 1'b0;
      rdy_q     <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lvl_q     <= lvl_d;
      wr_trig_q <= (state_d == ST_WR_REQ);
      rd_trig_q <= (state_d == ST_RD_REQ);
      rd_seen_q <= rd_seen_d;
      rdy_q     <= rdy_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign ctrl.wr_trig    = wr_trig_q;
  assign ctrl.rd_trig    = rd_trig_q;
  assign ctrl.burst_addr = addr_q;
  assign sdram_level     = lvl_q;
  assign rfifo_rd_ready  = rdy_q;
endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb/tb_sdram_burst_arbiter.sv - directed vector bench for sdram_burst_arbiter (1024-word ring)
module tb_sdram_burst_arbiter;
  localparam int CNT_W  = 9;
  localparam int ADDR_W = 22;
  localparam int BURST  = 256;
  localparam int MEM    = 1024;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [CNT_W-1:0]   wuse = '0;
  logic [CNT_W-1:0]   ruse = '0;
  logic [ADDR_W:0]    level;
  logic               rdy;
  int                 n_chk = 0;
  int                 n_fail = 0;

  sdram_burst_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  sdram_burst_arbiter #(
    .CNT_W(CNT_W), .FIFO_DEPTH(512), .BURST_LEN(BURST), .ADDR_W(ADDR_W),
    .MEM_WORDS(MEM), .RD_READY_LVL(243)
  ) dut (
    .wfifo_rclk(clk), .s_rst_n(rst_n), .wfifo_rside_usedw(wuse),
    .rfifo_wside_usedw(ruse), .ctrl(bus), .sdram_level(level), .rfifo_rd_ready(rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]  w, r;
    logic              wa, wd, ra, rd;
    logic              wt, rt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   lvl;
    logic              rdy;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input int w, input int r, input bit wa, input bit wd,
                              input bit ra, input bit rd, input bit wt, input bit rt,
                              input int addr, input int lvl, input bit rd_rdy);
    vec_t v;
    v.w = CNT_W'(w); v.r = CNT_W'(r);
    v.wa = wa; v.wd = wd; v.ra = ra; v.rd = rd;
    v.wt = wt; v.rt = rt;
    v.addr = ADDR_W'(addr); v.lvl = (ADDR_W + 1)'(lvl); v.rdy = rd_rdy;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    bus.wr_ack = 1'b0; bus.wr_done = 1'b0; bus.rd_ack = 1'b0; bus.rd_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wuse = '0; ruse = '0; clear_ctrl();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Wait for a trigger, check which channel and address, then ack and complete it.
  task automatic serve(input bit exp_wr, input int exp_addr, input string name);
    int n = 0;
    while (!bus.wr_trig && !bus.rd_trig && n < 50) begin
      tick();
      n++;
    end
    check({name, " trig seen"}, 32'(bus.wr_trig | bus.rd_trig), 1);
    check({name, " is write"}, 32'(bus.wr_trig), 32'(exp_wr));
    check({name, " addr"}, 32'(bus.burst_addr), exp_addr);
    if (bus.wr_trig) begin
      bus.wr_ack = 1'b1; tick(); bus.wr_ack = 1'b0;
      bus.wr_done = 1'b1; tick(); bus.wr_done = 1'b0;
    end else if (bus.rd_trig) begin
      bus.rd_ack = 1'b1; tick(); bus.rd_ack = 1'b0;
      bus.rd_done = 1'b1; tick(); bus.rd_done = 1'b0;
    end
  endtask

  initial begin
    int trig_cnt;
    //            w    r  wa wd ra rd wt rt addr lvl rdy
    vecs[0]  = mk(256, 0,   0, 0, 0, 0, 1, 0, 0,   0,   0);
    vecs[1]  = mk(256, 0,   0, 0, 1, 1, 1, 0, 0,   0,   0);
    vecs[2]  = mk(256, 0,   0, 0, 0, 0, 1, 0, 0,   0,   0);
    vecs[3]  = mk(256, 0,   1, 0, 0, 0, 0, 0, 0,   0,   0);
    vecs[4]  = mk(256, 0,   0, 0, 0, 0, 0, 0, 0,   0,   0);
    vecs[5]  = mk(256, 0,   0, 1, 0, 0, 0, 0, 0,   256, 0);
    vecs[6]  = mk(256, 300, 0, 0, 0, 0, 1, 0, 256, 256, 0);
    vecs[7]  = mk(256, 300, 1, 1, 0, 0, 0, 0, 256, 512, 0);
    vecs[8]  = mk(0,   0,   0, 0, 0, 0, 0, 1, 0,   512, 0);
    vecs[9]  = mk(0,   0,   1, 1, 0, 0, 0, 1, 0,   512, 0);
    vecs[10] = mk(0,   0,   0, 0, 1, 0, 0, 0, 0,   512, 0);
    vecs[11] = mk(0,   0,   0, 0, 0, 1, 0, 0, 0,   256, 0);
    vecs[12] = mk(0,   243, 0, 0, 0, 0, 0, 1, 256, 256, 1);
    vecs[13] = mk(0,   0,   0, 0, 1, 1, 0, 0, 256, 0,   1);
    vecs[14] = mk(0,   0,   0, 0, 0, 0, 0, 0, 256, 0,   1);
    vecs[15] = mk(0,   0,   0, 1, 0, 1, 0, 0, 256, 0,   1);

    clear_ctrl();
    repeat (2) tick();
    check("reset wr_trig", 32'(bus.wr_trig), 0);
    check("reset rd_trig", 32'(bus.rd_trig), 0);
    check("reset burst_addr", 32'(bus.burst_addr), 0);
    check("reset sdram_level", 32'(level), 0);
    check("reset rd_ready", 32'(rdy), 0);

    rst_n = 1'b1;
    trig_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.wr_trig || bus.rd_trig) trig_cnt++;
    end
    check("idle 100 cycles trig count", 32'(trig_cnt), 0);
    check("idle level", 32'(level), 0);

    for (int i = 0; i < 16; i++) begin
      wuse = vecs[i].w; ruse = vecs[i].r;
      bus.wr_ack = vecs[i].wa; bus.wr_done = vecs[i].wd;
      bus.rd_ack = vecs[i].ra; bus.rd_done = vecs[i].rd;
      tick();
      check($sformatf("v%0d wr_trig", i), 32'(bus.wr_trig), 32'(vecs[i].wt));
      check($sformatf("v%0d rd_trig", i), 32'(bus.rd_trig), 32'(vecs[i].rt));
      check($sformatf("v%0d burst_addr", i), 32'(bus.burst_addr), 32'(vecs[i].addr));
      check($sformatf("v%0d sdram_level", i), 32'(level), 32'(vecs[i].lvl));
      check($sformatf("v%0d rd_ready", i), 32'(rdy), 32'(vecs[i].rdy));
    end
    clear_ctrl();

    // Both channels pending once one burst is stored.
    do_reset();
    wuse = 256; ruse = 300;
    serve(1, 0, "arb setup");
    wuse = 300; ruse = 0;
`ifdef ARB_RR_EN
    serve(0, 0,   "arb 1");
    serve(1, 256, "arb 2");
    serve(0, 256, "arb 3");
    serve(1, 512, "arb 4");
    check("arb level", 32'(level), 256);
`else
    serve(1, 256, "arb 1");
    serve(1, 512, "arb 2");
    serve(1, 768, "arb 3");
    serve(0, 0,   "arb 4");
    check("arb level", 32'(level), 768);
`endif

    // Fill the ring, verify the full block, then one read frees a wrapped write.
    do_reset();
    wuse = 256; ruse = 300;
    for (int i = 0; i < 4; i++) serve(1, i * 256, $sformatf("fill %0d", i));
    check("full level", 32'(level), 1024);
    trig_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.wr_trig || bus.rd_trig) trig_cnt++;
    end
    check("full blocks trig", 32'(trig_cnt), 0);
    ruse = 0;
    serve(0, 0, "full drain");
    ruse = 300;
    serve(1, 0, "wrap write");
    check("wrap level", 32'(level), 1024);

    // Asynchronous reset while a request is outstanding.
    do_reset();
    wuse = 256; ruse = 300;
    tick();
    check("pre-reset wr_trig", 32'(bus.wr_trig), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset wr_trig", 32'(bus.wr_trig), 0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
SDRAM-clock-side burst scheduler between the write-path FIFO, the read-path FIFO and the SDRAM controller. It watches the FIFO fill counts and issues write or read burst triggers with a req/ack/done handshake. It generates wrapping burst base addresses, tracks how many words are held in SDRAM, and raises a sticky read-ready flag for the user side. All logic is in one clock domain; both FIFO counts arrive already in that domain.

Parameters:
CNT_W, 9, width of the FIFO data-count inputs
FIFO_DEPTH, 512, read-path FIFO depth in words
BURST_LEN, 256, words per SDRAM burst; a power of two ≤ FIFO_DEPTH
ADDR_W, 22, SDRAM word-address width
MEM_WORDS, 4194304, ring-buffer size in words; a multiple of BURST_LEN, ≤ 2**ADDR_W
RD_READY_LVL, 243, read-FIFO level that declares the user read path ready

Ports:
wfifo_rclk  in  1  clock (SDRAM-side clock)
s_rst_n  in  1  asynchronous active-low reset
wfifo_rside_usedw  in  CNT_W  words available in the write FIFO
rfifo_wside_usedw  in  CNT_W  words held in the read FIFO
wr_trig  out  1  write burst request
wr_ack  in  1  controller accepted write burst
wr_done  in  1  write burst finished (1-cycle pulse)
rd_trig  out  1  read burst request
rd_ack  in  1  controller accepted read burst
rd_done  in  1  read burst finished (1-cycle pulse)
burst_addr  out  ADDR_W  base address of the current burst
sdram_level  out  ADDR_W+1  words currently stored in SDRAM
rfifo_rd_ready  out  1  sticky: user may start reading

Behaviour:
- Reset state: reset is s_rst_n, asynchronous, active-low; the clock is wfifo_rclk. On reset, all outputs are 0, wr_ptr = 0, rd_ptr = 0, the FSM is in IDLE and the done-burst flag is clear.
- Pending conditions:
  - wr_pend = (wfifo_rside_usedw ≥ BURST_LEN) && (sdram_level ≤ MEM_WORDS − BURST_LEN).
  - rd_pend = (sdram_level ≥ BURST_LEN) && (rfifo_wside_usedw ≤ FIFO_DEPTH − BURST_LEN).
  - All comparisons are unsigned and zero-extended to ADDR_W+1 bits.
- FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY.
  - IDLE → WR_REQ when wr_pend is set and the write path is selected by arbitration.
  - IDLE → RD_REQ when rd_pend is set and the read path is selected by arbitration.
  - Otherwise the FSM stays in IDLE.
- Arbitration is fixed: a write wins whenever both wr_pend and rd_pend are set.
- Request states:
  - wr_trig is registered and equals 1 exactly while in WR_REQ; rd_trig likewise for RD_REQ. Latency from the pending condition becoming true in IDLE to trig = 1 is one cycle.
  - burst_addr is loaded with wr_ptr (or rd_ptr) on entry to the request state and is held until the FSM returns to IDLE.
  - WR_REQ → WR_BUSY on wr_ack; RD_REQ → RD_BUSY on rd_ack.
  - If ack and done arrive in the same cycle, the burst is treated as complete and the FSM goes straight to IDLE.
- Completion (on wr_done in WR_BUSY or rd_done in RD_BUSY):
  - Pointer advances by BURST_LEN; it wraps to 0 when the result equals MEM_WORDS.
  - sdram_level changes by +BURST_LEN on a write and −BURST_LEN on a read.
  - The FSM returns to IDLE. Level updates never coincide, because the FSM is serial.
- Ignored inputs:
  - ack and done outside their own REQ/BUSY states.
  - The other channel's ack and done in every state.
- rfifo_rd_ready: set once the first read burst has completed and rfifo_wside_usedw ≥ RD_READY_LVL; cleared only by reset.
- Full and empty boundaries:
  - sdram_level = MEM_WORDS blocks writes, and write data accumulates in the FIFO.
  - sdram_level = 0 blocks reads, so no read is issued before the first write completes.
- Reset mid-burst drops the request immediately; controller-side cleanup is owned by the controller.

Optional Feature:
ARB_RR_EN: when defined, IDLE arbitration is round-robin. A 1-bit last-served register (reset = read) grants the channel not served last when both are pending. When undefined, arbitration is fixed write priority as above. Single-pending behaviour is identical in both builds.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - the FSM state enum;
  - a BURST_LEN legality check function (power of two, divides MEM_WORDS).
- One natural sub-module, burst_ptr, instantiated twice (write and read): holds the ADDR_W pointer and does the advance-by-BURST_LEN with wrap at MEM_WORDS.

Test Plan:
1. Reset with usedw = 0 → all outputs 0, FSM in IDLE, no trig for 100 cycles.
2. wfifo_rside_usedw = 256 → wr_trig = 1 next cycle with burst_addr = 0 and held until wr_ack; after wr_done, sdram_level = 256 and the next write uses burst_addr = 256.
3. After one write with rfifo_wside_usedw = 0 → rd_trig with burst_addr = 0; after rd_done, sdram_level = 0. Then drive rfifo_wside_usedw = 243 → rfifo_rd_ready = 1 and it stays high.
4. Both pending (sdram_level = 256, wfifo = 300, rfifo = 0) → write served first. With ARB_RR_EN defined: read, write, read, write alternation.
5. MEM_WORDS = 1024, BURST_LEN = 256, wfifo held at 256 → writes at 0, 256, 512, 768, then wr_trig stays low at sdram_level = 1024; one read releases a write at 0 (wrap).
6. Controller sends rd_ack in WR_REQ, wr_done in IDLE, and ack with done in the same cycle → the stray inputs are ignored; the same-cycle pair completes the burst and returns to IDLE.
